timer_display_scan: RTL and testbench

Display-side consumer of the three-digit BCD countdown timer. Samples the timer's minutes, seconds-tens and seconds-units digits plus its `zero` flag once per display frame and drives a time-multiplexed, three-digit, seven-segment display. The block sits between the timer and the board's display pins. It blinks the whole display while the countdown is at zero.

---
 rtl/timer_disp_pkg.sv | 36 +++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/timer_display_scan.sv | 140 ++++++++++++++
 tb/tb_timer_display_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/timer_disp_pkg.sv
// Shared constants for the timer display path: seven-segment patterns
// (active-high, bit 0 = a ... bit 6 = g), digit index values and the
// one-hot anode mapping for each digit position.
package timer_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] IDX_MIN = 2'd0;
  localparam logic [1:0] IDX_ST  = 2'd1;
  localparam logic [1:0] IDX_SO  = 2'd2;

  // Largest legal value for a plain decimal digit and for the seconds-tens digit.
  localparam logic [3:0] MAX_DEC       = 4'd9;
  localparam logic [3:0] MAX_SEC_TENS  = 4'd5;

  // Anode enable for a digit index: min on bit 2, st on bit 1, so on bit 0.
  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    case (idx)
      IDX_MIN: idx_onehot = 3'b100;
      IDX_ST:  idx_onehot = 3'b010;
      default: idx_onehot = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder. Values above max_digit
// (9 for ordinary digits, 5 for seconds-tens) show a dash so that a
// corrupt timer digit is visible rather than silently wrapped.
module bcd_to_7seg
  import timer_disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic [3:0] max_digit,
  output logic [6:0] seg
);

  // Table lookup with the range check folded in ahead of it.
  always_comb begin
    seg = SEG_DASH;
    if (value <= max_digit) begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/timer_display_scan.sv
// Three-digit multiplexed seven-segment driver for the countdown timer.
// A prescaler paces the digit scan; at each frame start the timer digits
// and zero flag are snapshotted so one frame never mixes two timer values.
// While the zero snapshot is high the whole display blinks with a
// half-period of BLINK_FRAMES frames. All outputs are registered and only
// move on the edge that ends a tick cycle.
module timer_display_scan
  import timer_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] min,
  input  logic [3:0] st,
  input  logic [3:0] so,
  input  logic       zero,
  input  logic       blank_lead,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  logic [PCW-1:0] pc;
  logic [1:0]     idx;
  logic [3:0]     snap_min, snap_st, snap_so;
  logic           snap_zero;
  logic [FCW-1:0] fc;
  logic           ph;

  logic           tick, frame_start;
  logic [1:0]     idx_nxt;
  logic [3:0]     cur_min, cur_st, cur_so;
  logic [FCW-1:0] fc_nxt;
  logic           ph_nxt;
  logic [3:0]     digit_val, digit_max;
  logic [6:0]     digit_seg;
  logic           blank_min;

  assign tick        = (pc == PC_LAST);
  assign frame_start = tick && (idx == IDX_SO);
  assign idx_nxt     = (idx == IDX_SO) ? IDX_MIN : idx + 2'd1;

  // At frame start the first digit must come from the value being captured
  // on this same edge, so bypass the snapshot registers then.
  assign cur_min = frame_start ? min : snap_min;
  assign cur_st  = frame_start ? st  : snap_st;
  assign cur_so  = frame_start ? so  : snap_so;

  // Blink bookkeeping per frame. The frame in which zero first appears is
  // counted as the first lit frame, so fc restarts at 0 with ph held at 1.
  always_comb begin
    fc_nxt = fc;
    ph_nxt = ph;
    if (frame_start) begin
      if (!zero || !snap_zero) begin
        fc_nxt = '0;
        ph_nxt = 1'b1;
      end else if (fc == FC_LAST) begin
        fc_nxt = '0;
        ph_nxt = ~ph;
      end else begin
        fc_nxt = fc + FCW'(1);
      end
    end
  end

  // Select the digit about to be shown and its legal range.
  always_comb begin
    digit_val = cur_so;
    digit_max = MAX_DEC;
    case (idx_nxt)
      IDX_MIN: begin digit_val = cur_min; digit_max = MAX_DEC;      end
      IDX_ST:  begin digit_val = cur_st;  digit_max = MAX_SEC_TENS; end
      default: begin digit_val = cur_so;  digit_max = MAX_DEC;      end
    endcase
  end

  assign blank_min = (idx_nxt == IDX_MIN) && blank_lead && (cur_min == 4'd0);

  bcd_to_7seg u_dec (
    .value     (digit_val),
    .max_digit (digit_max),
    .seg       (digit_seg)
  );

  // Prescaler and digit index; reset parks them one cycle before a frame start.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pc  <= PC_LAST;
      idx <= IDX_SO;
    end else if (tick) begin
      pc  <= '0;
      idx <= idx_nxt;
    end else begin
      pc  <= pc + PCW'(1);
    end
  end

  // Frame snapshot of the timer digits plus the blink counter and phase.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      snap_min  <= '0;
      snap_st   <= '0;
      snap_so   <= '0;
      snap_zero <= 1'b0;
      fc        <= '0;
      ph        <= 1'b1;
    end else begin
      if (frame_start) begin
        snap_min  <= min;
        snap_st   <= st;
        snap_so   <= so;
        snap_zero <= zero;
      end
      fc <= fc_nxt;
      ph <= ph_nxt;
    end
  end

  // Output registers, updated once per digit slot.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      an  <= 3'b000;
      seg <= SEG_OFF;
      dp  <= 1'b0;
    end else if (tick) begin
      an  <= ph_nxt ? idx_onehot(idx_nxt) : 3'b000;
      seg <= blank_min ? SEG_OFF : digit_seg;
      dp  <= (idx_nxt == IDX_MIN);
    end
  end

endmodule

// File: tb/tb_timer_display_scan.sv
// Bench for timer_display_scan with SCAN_DIV = 4, BLINK_FRAMES = 2.
// The reference model counts edges since reset release and derives the
// digit slot, frame number, snapshot and blink visibility arithmetically.
module tb_timer_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 3 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] min = 4'd0, st = 4'd0, so = 4'd0;
  logic       zero = 1'b0, blank_lead = 1'b0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  timer_display_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .min        (min),
    .st         (st),
    .so         (so),
    .zero       (zero),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         k;          // edges since reset release
  int         zero_run;   // consecutive frames whose zero snapshot is 1
  logic [3:0] m_min, m_st, m_so;
  logic [2:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at k=%0d: got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; zero_run = 0;
    m_min = 0; m_st = 0; m_so = 0;
    exp_an = 3'b000; exp_seg = 7'h00; exp_dp = 1'b0;
  endtask

  // Called just after each rising edge; inputs are those present at the edge.
  task automatic model_edge();
    int slot;
    int v;
    int maxd;
    bit visible;
    if (k % FRAME == 0) begin
      m_min = min; m_st = st; m_so = so;
      if (zero) zero_run++; else zero_run = 0;
    end
    if (k % SCAN_DIV == 0) begin
      slot    = (k / SCAN_DIV) % 3;
      visible = (zero_run == 0) || ((((zero_run - 1) / BLINK_FRAMES) % 2) == 0);
      exp_an  = visible ? 3'(3'b100 >> slot) : 3'b000;
      case (slot)
        0:       begin v = m_min; maxd = 9; end
        1:       begin v = m_st;  maxd = 5; end
        default: begin v = m_so;  maxd = 9; end
      endcase
      exp_seg = (v > maxd) ? 7'h40 : seg_tab[v];
      if (slot == 0 && blank_lead && m_min == 0) exp_seg = 7'h00;
      exp_dp = (slot == 0);
    end
    k++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("an",  32'(an),  32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp",  32'(dp),  32'(exp_dp));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},  32'(an),  32'(0));
    check({tag, "_seg"}, 32'(seg), 32'(0));
    check({tag, "_dp"},  32'(dp),  32'(0));
  endtask

  // Called at a negedge: release reset; the next edge is a frame start.
  task automatic release_reset();
    clear = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    min = 4'd3; st = 4'd4; so = 4'd7;
    repeat (2) @(negedge clk);
    check_off("reset");
    release_reset();

    // First frame: 100/4F dp, 010/66, 001/07.
    run(FRAME);

    // Snapshot coherence: so changes during the min digit.
    cycle();
    so = 4'd2;
    run(FRAME - 1);
    run(FRAME);

    // Invalid digits show a dash.
    st = 4'd6; so = 4'd12;
    run(FRAME);
    run(FRAME);

    // Leading blank on, then off.
    st = 4'd1; so = 4'd5; min = 4'd0; blank_lead = 1'b1;
    run(2 * FRAME);
    blank_lead = 1'b0;
    run(FRAME);

    // Blink: zero held for several half-periods, then dropped.
    zero = 1'b1; min = 4'd0; st = 4'd0; so = 4'd0;
    run(9 * FRAME);
    zero = 1'b0;
    run(3 * FRAME);

    // Mid-frame reset during the st digit.
    while ((k % FRAME) != SCAN_DIV + 2) cycle();
    min = 4'd8; st = 4'd5; so = 4'd9;
    clear = 1'b1;
    #1;
    check_off("async_clear");
    @(negedge clk);
    check_off("held_clear");
    @(negedge clk);
    release_reset();
    run(2 * FRAME);

    // Randomized traffic with occasional long zero runs.
    for (int i = 0; i < 60 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        min        = 4'($urandom_range(0, 15));
        st         = 4'($urandom_range(0, 7));
        so         = 4'($urandom_range(0, 15));
        blank_lead = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) min = 4'd0;
      end
      if ($urandom_range(0, 99) == 0) zero = ~zero;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
